mp_booth_host: RTL

MP_BOOTH_HOST -- requirements
Module: mp_booth_host

---
 rtl/mp_booth_host.sv | 113 +++++++++++
 1 files changed

// File: rtl/mp_booth_host.sv
// Batch host for a FIFO-style multiplier: streams operand pairs in, turns the
// bus around, then streams product words out. Words are passed through untouched.
module mp_booth_host #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_num_pairs,
  input  logic [15:0] i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic [15:0] o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_bus_wdata,
  input  logic [15:0] i_bus_rdata,
  output logic        o_bus_rw,
  output logic        o_bus_en,
  input  logic        i_bus_empty,
  input  logic        i_bus_full,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_TURN, S_READ, S_DONE, S_ERROR
  } state_t;

  state_t          r_state;
  logic [1:0]      r_np;
  logic [2:0]      r_cnt;
  logic [TW-1:0]   r_tmo;
  logic            r_err;

  logic            w_last;
  logic            w_wr_xfer;
  logic            w_rd_xfer;

  // Batch is 2*(np+1) words each way, so the last word index is {np,1}.
  assign w_last    = (r_cnt == {r_np, 1'b1});
  assign w_wr_xfer = (r_state == S_WRITE) && i_in_valid && !i_bus_full;
  assign w_rd_xfer = (r_state == S_READ) && i_out_ready && !i_bus_empty;

  // Bus strobes are combinational so a word moves on the same edge the
  // upstream/downstream handshake completes; all gate on state, so reset
  // drops them immediately.
  assign o_bus_en    = w_wr_xfer || w_rd_xfer;
  assign o_bus_rw    = (r_state == S_TURN) || (r_state == S_READ);
  assign o_bus_wdata = (r_state == S_WRITE) ? i_in_data : 16'h0000;
  assign o_in_ready  = (r_state == S_WRITE) && !i_bus_full;
  assign o_out_data  = (r_state == S_READ) ? i_bus_rdata : 16'h0000;
  assign o_out_valid = (r_state == S_READ) && !i_bus_empty;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_np    <= 2'd0;
      r_cnt   <= 3'd0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_np    <= i_num_pairs;
            r_cnt   <= 3'd0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Full stalls here with no timeout; the word stays on in_data.
          if (w_wr_xfer) begin
            if (w_last) r_state <= S_TURN;
            else        r_cnt   <= r_cnt + 3'd1;
          end
        end
        S_TURN: begin
          r_cnt   <= 3'd0;
          r_tmo   <= '0;
          r_state <= S_READ;
        end
        S_READ: begin
          if (w_rd_xfer) begin
            r_tmo <= '0;
            if (w_last) r_state <= S_DONE;
            else        r_cnt   <= r_cnt + 3'd1;
          end else if (i_bus_empty) begin
            // Only empty cycles count; a result held back by out_ready does not.
            if (r_tmo == TW'(TIMEOUT - 1)) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERROR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
